// File: rtl/zjh_pkg.sv
`default_nettype none
// ============================================================================
// Module : zjh_pkg
// Brief  : Shared state encodings and sample width for the zjh accumulator.
// Rev    : 1.0  initial release
// ============================================================================
package zjh_pkg;

    localparam int SMP_W = 4;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/zjh_sat_add.sv
`default_nettype none
// ============================================================================
// Module : zjh_sat_add
// Brief  : Combinational saturating add of a 4-bit signed sample into an
//          SUM_W-bit signed accumulator, with a clamp-engaged flag.
// Rev    : 1.0  initial release
// ============================================================================
module zjh_sat_add
    import zjh_pkg::*;
#(
    parameter int SUM_W = 8
) (
    input  logic [SUM_W-1:0] i_acc,
    input  logic [SMP_W-1:0] i_sample,
    output logic [SUM_W-1:0] o_result,
    output logic             o_sat
);

    logic [SUM_W:0] w_acc_ext;
    logic [SUM_W:0] w_smp_ext;
    logic [SUM_W:0] w_sum;

    assign w_acc_ext = {i_acc[SUM_W-1], i_acc};
    assign w_smp_ext = {{(SUM_W+1-SMP_W){i_sample[SMP_W-1]}}, i_sample};
    assign w_sum     = w_acc_ext + w_smp_ext;

    // The wide sum cannot overflow; the top two bits differ only when the
    // true result is outside the SUM_W-bit range, and the MSB gives its sign.
    always_comb begin
        o_sat    = (w_sum[SUM_W] != w_sum[SUM_W-1]);
        o_result = w_sum[SUM_W-1:0];
        if (o_sat) begin
            if (w_sum[SUM_W]) begin
                o_result = {1'b1, {(SUM_W-1){1'b0}}};
            end else begin
                o_result = {1'b0, {(SUM_W-1){1'b1}}};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/zjh_cc_acc.sv
`default_nettype none
// ============================================================================
// Module : zjh_cc_acc
// Brief  : Frame accumulator: sums N_SAMPLES signed 4-bit samples with
//          saturation and hands the result out over valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
module zjh_cc_acc
    import zjh_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int SUM_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SMP_W-1:0] A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] SUM,
    output logic             OVF,
    output logic [3:0]       CNT
);

    localparam logic [3:0] C_LAST = 4'(N_SAMPLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] w_sum_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;

    logic [SUM_W-1:0] w_sat_sum;
    logic             w_sat;
    logic             w_accept;
    logic             w_unload;

    zjh_sat_add #(
        .SUM_W (SUM_W)
    ) u_sat_add (
        .i_acc    (r_sum),
        .i_sample (A),
        .o_result (w_sat_sum),
        .o_sat    (w_sat)
    );

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_unload  = out_ready && out_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        // clr outranks both handshakes: the in-flight sample and any pending
        // result are both thrown away.
        if (clr) begin
            w_state_nxt = ST_ACC;
            w_sum_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end else if (w_accept) begin
            w_sum_nxt = w_sat_sum;
            w_ovf_nxt = r_ovf | w_sat;
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == C_LAST) begin
                w_state_nxt = ST_DONE;
            end
        end else if (w_unload) begin
            w_state_nxt = ST_ACC;
            w_sum_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sum   <= w_sum_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign SUM = r_sum;
    assign OVF = r_ovf;
    assign CNT = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_zjh_cc_acc.sv
`default_nettype none
// ============================================================================
// Module : tb_zjh_cc_acc
// Brief  : Scoreboard bench for zjh_cc_acc using three parameter sets.
// Rev    : 1.0  initial release
// ============================================================================
module tb_zjh_cc_acc;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr  [3];
    logic       iv   [3];
    logic [3:0] a    [3];
    logic       ordy [3];
    logic       ir   [3];
    logic       ov   [3];
    logic       ovf  [3];
    logic [3:0] cnt  [3];
    logic [7:0] sum0;
    logic [4:0] sum1;
    logic [5:0] sum2;
    logic [15:0] sx  [3];

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int nk[3] = '{4, 4, 7};

    always #5 clk = ~clk;

    zjh_cc_acc #(.N_SAMPLES(4), .SUM_W(8)) dut0 (
        .clk(clk), .rst(rst), .clr(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .A(a[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .SUM(sum0),
        .OVF(ovf[0]), .CNT(cnt[0]));

    zjh_cc_acc #(.N_SAMPLES(4), .SUM_W(5)) dut1 (
        .clk(clk), .rst(rst), .clr(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .A(a[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .SUM(sum1),
        .OVF(ovf[1]), .CNT(cnt[1]));

    zjh_cc_acc #(.N_SAMPLES(7), .SUM_W(6)) dut2 (
        .clk(clk), .rst(rst), .clr(clr[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .A(a[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .SUM(sum2),
        .OVF(ovf[2]), .CNT(cnt[2]));

    always_comb begin
        sx[0] = {{8{sum0[7]}}, sum0};
        sx[1] = {{11{sum1[4]}}, sum1};
        sx[2] = {{10{sum2[5]}}, sum2};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [15:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Monitor: every output handshake pops the oldest expected frame result.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ov[k] && ordy[k]) begin
                exp_t e;
                logic got;
                got = 1'b0;
                e   = '0;
                case (k)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                endcase
                chk($sformatf("dut%0d_unexpected_result", k), 32'(got), 32'd1);
                if (got) begin
                    chk($sformatf("dut%0d_SUM", k), 32'(sx[k]), 32'(e.sum));
                    chk($sformatf("dut%0d_OVF", k), 32'(ovf[k]), 32'(e.ovf));
                    chk($sformatf("dut%0d_CNT_done", k), 32'(cnt[k]), 32'(nk[k]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [3:0] v);
        int n;
        n     = 0;
        a[k]  = v;
        iv[k] = 1'b1;
        while (!ir[k] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk($sformatf("dut%0d_send_timeout", k), 32'd1, 32'd0);
        tick();
        iv[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b0; iv[k] = 1'b0; a[k] = 4'd0; ordy[k] = 1'b1;
        end
        tick(); tick();
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_SUM", 32'(sx[0]), 32'd0);
        chk("rst_OVF", 32'(ovf[0]), 32'd0);
        chk("rst_CNT", 32'(cnt[0]), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(ir[0]), 32'd1);

        // 1: +3 +2 -1 +4 back to back
        push(0, 16'd8, 1'b0);
        send(0, 4'd3);
        chk("t1_latency_SUM", 32'(sx[0]), 32'd3);
        chk("t1_latency_CNT", 32'(cnt[0]), 32'd1);
        send(0, 4'd2);
        send(0, 4'hF);
        send(0, 4'd4);
        chk("t1_out_valid_on_last", 32'(ov[0]), 32'd1);
        tick();
        chk("t1_back_to_acc", 32'(ir[0]), 32'd1);

        // 2: saturate at +31 (SUM_W=6), then -8 from the clamped value
        push(2, 16'd23, 1'b1);
        send(2, 4'd7); send(2, 4'd7); send(2, 4'd7); send(2, 4'd7);
        send(2, 4'd3);
        chk("t2_at_max", 32'(sx[2]), 32'd31);
        chk("t2_no_ovf_yet", 32'(ovf[2]), 32'd0);
        send(2, 4'd1);
        chk("t2_sat_SUM", 32'(sx[2]), 32'd31);
        chk("t2_sat_OVF", 32'(ovf[2]), 32'd1);
        send(2, 4'h8);
        chk("t2_sticky_OVF", 32'(ovf[2]), 32'd1);
        tick();

        // 3: four -8 samples, wide and narrow accumulators
        push(0, 16'hFFE0, 1'b0);
        for (int i = 0; i < 4; i++) send(0, 4'h8);
        push(1, 16'hFFF0, 1'b1);
        for (int i = 0; i < 4; i++) send(1, 4'h8);
        tick();

        // 4: result held while out_ready=0, inputs blocked
        ordy[0] = 1'b0;
        push(0, 16'd10, 1'b0);
        send(0, 4'd1); send(0, 4'd2); send(0, 4'd3); send(0, 4'd4);
        a[0]  = 4'd5;
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_in_ready_low", 32'(ir[0]), 32'd0);
            chk("t4_hold_SUM", 32'(sx[0]), 32'd10);
            chk("t4_hold_CNT", 32'(cnt[0]), 32'd4);
            tick();
        end
        ordy[0] = 1'b1;
        tick();
        chk("t4_unload_CNT", 32'(cnt[0]), 32'd0);
        chk("t4_unload_SUM", 32'(sx[0]), 32'd0);
        chk("t4_unload_valid", 32'(ov[0]), 32'd0);
        tick();
        chk("t4_next_accept_CNT", 32'(cnt[0]), 32'd1);
        chk("t4_next_accept_SUM", 32'(sx[0]), 32'd5);
        iv[0] = 1'b0;

        // 5: clr after +5,+5 with a sample presented alongside
        send(0, 4'd5);
        chk("t5_pre_clr_SUM", 32'(sx[0]), 32'd10);
        clr[0] = 1'b1;
        iv[0]  = 1'b1;
        a[0]   = 4'd7;
        tick();
        clr[0] = 1'b0;
        iv[0]  = 1'b0;
        chk("t5_clr_SUM", 32'(sx[0]), 32'd0);
        chk("t5_clr_CNT", 32'(cnt[0]), 32'd0);
        push(0, 16'd6, 1'b0);
        send(0, 4'd1); send(0, 4'd1); send(0, 4'd2); send(0, 4'd2);
        tick();

        // 6: reset in DONE, then gapped in_valid
        ordy[1] = 1'b0;
        send(1, 4'd1); send(1, 4'd2); send(1, 4'd3); send(1, 4'd4);
        chk("t6_in_done", 32'(ov[1]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", 32'(ov[1]), 32'd0);
        chk("t6_rst_SUM", 32'(sx[1]), 32'd0);
        chk("t6_rst_ready", 32'(ir[1]), 32'd1);
        ordy[1] = 1'b1;
        push(1, 16'd10, 1'b0);
        iv[1] = 1'b1; a[1] = 4'd2; tick();
        iv[1] = 1'b0; a[1] = 4'd7; tick();
        iv[1] = 1'b1; a[1] = 4'd3; tick();
        iv[1] = 1'b0;
        chk("t6_gap_CNT", 32'(cnt[1]), 32'd2);
        chk("t6_gap_SUM", 32'(sx[1]), 32'd5);
        send(1, 4'd1); send(1, 4'd4);
        tick(); tick();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
